// File: rtl/eoc_column_fifo.sv
// End-of-column FIFO: stamps arbiter hits with TimeStamp/COL_ID, buffers them, grants the arbiter,
// and drains first-word-fall-through over valid/ready. EOC_FIFO_HWM_EN adds an occupancy high-water mark.
`timescale 1ns/1ps
module eoc_column_fifo #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned AW     = 3,
  parameter logic [3:0]  COL_ID = 4'd0
) (
  input  logic          clk_40MHz,
  input  logic          rst_n,
  input  logic [26:0]   data_eoc_arbiter,
  input  logic [8:0]    TimeStamp,
  input  logic          col_enable,
  output logic          shake_hands_col,
  input  logic          dout_ready,
  output logic          dout_valid,
  output logic [39:0]   dout,
  output logic [AW:0]   fifo_count
`ifdef EOC_FIFO_HWM_EN
  ,
  output logic [AW:0]   fifo_hwm,
  input  logic          hwm_clr
`endif
);

  localparam int unsigned DATA_W = 27;
  localparam int unsigned TS_W   = 9;
  localparam int unsigned WORD_W = 4 + TS_W + DATA_W;
  localparam int unsigned CW     = AW + 1;

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_grant;

  logic              w_wr;
  logic              w_rd;
  logic [CW-1:0]     w_count_next;

  // Select bit alone is not a hit; the grant already guarantees a free slot.
  assign w_wr         = r_grant & (|data_eoc_arbiter[DATA_W-1:1]);
  assign w_rd         = dout_valid & dout_ready;
  assign w_count_next = r_count + CW'(w_wr) - CW'(w_rd);

  assign shake_hands_col = r_grant;
  assign dout_valid      = (r_count != '0);
  assign dout            = r_mem[r_rd_ptr];
  assign fifo_count      = r_count;

  // Storage is intentionally not reset; pointers alone define validity.
  always_ff @(posedge clk_40MHz) begin
    if (rst_n && w_wr) begin
      r_mem[r_wr_ptr] <= {COL_ID, TimeStamp, data_eoc_arbiter};
    end
  end

  always_ff @(posedge clk_40MHz) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_grant  <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_next;
      r_grant <= col_enable & (w_count_next < CW'(DEPTH));
    end
  end

`ifdef EOC_FIFO_HWM_EN
  logic [CW-1:0] r_hwm;

  assign fifo_hwm = r_hwm;

  // Clear reloads with the upcoming occupancy rather than zero so a non-empty FIFO stays tracked.
  always_ff @(posedge clk_40MHz) begin
    if (!rst_n) begin
      r_hwm <= '0;
    end else if (hwm_clr) begin
      r_hwm <= w_count_next;
    end else if (w_count_next > r_hwm) begin
      r_hwm <= w_count_next;
    end
  end
`endif

endmodule

// File: tb/tb_eoc_column_fifo.sv
// Scoreboard bench for eoc_column_fifo: expected words queued on predicted writes, popped on reads.
`timescale 1ns/1ps
module tb_eoc_column_fifo;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned AW     = 3;
  localparam int unsigned CW     = AW + 1;
  localparam logic [3:0]  COL_ID = 4'h0;

  logic          clk_40MHz = 1'b0;
  logic          rst_n;
  logic [26:0]   data_eoc_arbiter;
  logic [8:0]    TimeStamp;
  logic          col_enable;
  logic          shake_hands_col;
  logic          dout_ready;
  logic          dout_valid;
  logic [39:0]   dout;
  logic [AW:0]   fifo_count;
`ifdef EOC_FIFO_HWM_EN
  logic [AW:0]   fifo_hwm;
  logic          hwm_clr;
  int            m_hwm;
`endif

  int            n_checks;
  int            n_pass;
  logic [39:0]   sb_q[$];
  int            m_count;
  bit            m_grant;

  always #12.5 clk_40MHz = ~clk_40MHz;

  eoc_column_fifo #(.DEPTH(DEPTH), .AW(AW), .COL_ID(COL_ID)) dut (
    .clk_40MHz        (clk_40MHz),
    .rst_n            (rst_n),
    .data_eoc_arbiter (data_eoc_arbiter),
    .TimeStamp        (TimeStamp),
    .col_enable       (col_enable),
    .shake_hands_col  (shake_hands_col),
    .dout_ready       (dout_ready),
    .dout_valid       (dout_valid),
    .dout             (dout),
    .fifo_count       (fifo_count)
`ifdef EOC_FIFO_HWM_EN
    ,
    .fifo_hwm         (fifo_hwm),
    .hwm_clr          (hwm_clr)
`endif
  );

  function automatic logic [26:0] mkdata(input int n);
    mkdata = {26'(n + 1), 1'(n)};
  endfunction

  // One clock: drive at negedge, score any read, advance the model, check state after the edge.
  task automatic step(input logic [26:0] d, input logic [8:0] t, input logic en,
                      input logic rdy, input logic rst_b);
    logic [39:0] exp_w;
    bit m_wr;
    bit m_rd;
    @(negedge clk_40MHz);
    data_eoc_arbiter = d;
    TimeStamp        = t;
    col_enable       = en;
    dout_ready       = rdy;
    rst_n            = rst_b;
    #1;
    m_wr = m_grant && (d[26:1] != 26'd0);
    m_rd = (m_count != 0) && rdy;
    if (!rst_b) begin
      sb_q.delete();
      m_count = 0;
      m_grant = 1'b0;
`ifdef EOC_FIFO_HWM_EN
      m_hwm = 0;
`endif
    end else begin
      if (m_rd) begin
        exp_w = sb_q.pop_front();
        n_checks++;
        if (dout_valid !== 1'b1 || dout !== exp_w)
          $display("FAIL sb_word t=%0t valid=%b dout=%h expected=%h", $time, dout_valid, dout, exp_w);
        else n_pass++;
      end
      if (m_wr) sb_q.push_back({COL_ID, t, d});
      m_count = m_count + int'(m_wr) - int'(m_rd);
      m_grant = en && (m_count < DEPTH);
`ifdef EOC_FIFO_HWM_EN
      if (hwm_clr) m_hwm = m_count;
      else if (m_count > m_hwm) m_hwm = m_count;
`endif
    end
    @(posedge clk_40MHz);
    #1;
    n_checks++;
    if (fifo_count !== CW'(m_count) || shake_hands_col !== m_grant || dout_valid !== (m_count != 0))
      $display("FAIL state t=%0t count=%0d grant=%b valid=%b expected count=%0d grant=%b valid=%b",
               $time, fifo_count, shake_hands_col, dout_valid, m_count, m_grant, (m_count != 0));
    else n_pass++;
`ifdef EOC_FIFO_HWM_EN
    n_checks++;
    if (fifo_hwm !== CW'(m_hwm))
      $display("FAIL hwm t=%0t hwm=%0d expected=%0d", $time, fifo_hwm, m_hwm);
    else n_pass++;
`endif
  endtask

  task automatic test_reset();
    step(27'h0, 9'h0, 1'b1, 1'b0, 1'b0);
    step(27'h0, 9'h0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (fifo_count !== 4'd0 || shake_hands_col !== 1'b0 || dout_valid !== 1'b0)
      $display("FAIL reset count=%0d grant=%b valid=%b expected 0/0/0", fifo_count, shake_hands_col, dout_valid);
    else n_pass++;
  endtask

  task automatic test_single_write();
    step(27'h0, 9'h0, 1'b1, 1'b0, 1'b1);
    step(27'h00000A5, 9'h012, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (dout_valid !== 1'b1 || dout !== {4'h0, 9'h012, 27'h00000A5} || fifo_count !== 4'd1)
      $display("FAIL single_write valid=%b dout=%h count=%0d expected 1/%h/1",
               dout_valid, dout, fifo_count, {4'h0, 9'h012, 27'h00000A5});
    else n_pass++;
  endtask

  task automatic test_fill_full();
    for (int i = 0; i < 10; i++) step(mkdata(100 + i), 9'(i), 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (fifo_count !== 4'd8 || shake_hands_col !== 1'b0)
      $display("FAIL fill_full count=%0d grant=%b expected 8/0", fifo_count, shake_hands_col);
    else n_pass++;
    step(mkdata(200), 9'h1FF, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (fifo_count !== 4'd7 || shake_hands_col !== 1'b1)
      $display("FAIL full_pop count=%0d grant=%b expected 7/1", fifo_count, shake_hands_col);
    else n_pass++;
  endtask

  task automatic test_full_stream();
    for (int i = 0; i < 20; i++) step(mkdata(300 + i), 9'(40 + i), 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (fifo_count < 4'd7)
      $display("FAIL stream_level count=%0d expected >=7", fifo_count);
    else n_pass++;
    for (int i = 0; i < 10; i++) step(27'h0, 9'h0, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (fifo_count !== 4'd0 || dout_valid !== 1'b0 || sb_q.size() != 0)
      $display("FAIL stream_drain count=%0d valid=%b left=%0d expected 0/0/0", fifo_count, dout_valid, sb_q.size());
    else n_pass++;
  endtask

  task automatic test_select_only();
    for (int i = 0; i < 3; i++) step(27'h0000001, 9'h055, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (fifo_count !== 4'd0 || dout_valid !== 1'b0 || shake_hands_col !== 1'b1)
      $display("FAIL select_only count=%0d valid=%b grant=%b expected 0/0/1", fifo_count, dout_valid, shake_hands_col);
    else n_pass++;
    // Underflow: ready while empty must not move the read pointer
    step(27'h0, 9'h0, 1'b1, 1'b1, 1'b1);
    step(mkdata(77), 9'h077, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (dout !== {COL_ID, 9'h077, mkdata(77)})
      $display("FAIL underflow dout=%h expected=%h", dout, {COL_ID, 9'h077, mkdata(77)});
    else n_pass++;
    step(27'h0, 9'h0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_disable_drain();
    for (int i = 0; i < 3; i++) step(mkdata(400 + i), 9'(80 + i), 1'b1, 1'b0, 1'b1);
    step(27'h0, 9'h0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (shake_hands_col !== 1'b0)
      $display("FAIL disable_grant grant=%b expected 0", shake_hands_col);
    else n_pass++;
    for (int i = 0; i < 3; i++) step(mkdata(500 + i), 9'(90 + i), 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (fifo_count !== 4'd0 || dout_valid !== 1'b0)
      $display("FAIL disable_drain count=%0d valid=%b expected 0/0", fifo_count, dout_valid);
    else n_pass++;
  endtask

`ifdef EOC_FIFO_HWM_EN
  task automatic test_hwm();
    step(27'h0, 9'h0, 1'b1, 1'b0, 1'b0);
    step(27'h0, 9'h0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(mkdata(600 + i), 9'(i), 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(27'h0, 9'h0, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (fifo_hwm !== 4'd5 || fifo_count !== 4'd0)
      $display("FAIL hwm_peak hwm=%0d count=%0d expected 5/0", fifo_hwm, fifo_count);
    else n_pass++;
    hwm_clr = 1'b1;
    step(27'h0, 9'h0, 1'b1, 1'b0, 1'b1);
    hwm_clr = 1'b0;
    n_checks++;
    if (fifo_hwm !== 4'd0)
      $display("FAIL hwm_clear hwm=%0d expected 0", fifo_hwm);
    else n_pass++;
  endtask
`endif

  task automatic test_reset_mid_fill();
    for (int i = 0; i < 3; i++) step(mkdata(700 + i), 9'(i), 1'b1, 1'b0, 1'b1);
    step(mkdata(710), 9'h0AA, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (fifo_count !== 4'd0 || shake_hands_col !== 1'b0 || dout_valid !== 1'b0)
      $display("FAIL reset_mid count=%0d grant=%b valid=%b expected 0/0/0", fifo_count, shake_hands_col, dout_valid);
    else n_pass++;
    step(27'h0, 9'h0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic [26:0] d;
    for (int i = 0; i < 300; i++) begin
      d = ($urandom_range(0, 3) == 0) ? 27'($urandom_range(0, 1)) : mkdata(1000 + i);
      step(d, 9'($urandom), ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 1'b1);
    end
    for (int i = 0; i < 10; i++) step(27'h0, 9'h0, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (fifo_count !== 4'd0 || sb_q.size() != 0)
      $display("FAIL random_drain count=%0d left=%0d expected 0/0", fifo_count, sb_q.size());
    else n_pass++;
  endtask

  initial begin
    n_checks         = 0;
    n_pass           = 0;
    m_count          = 0;
    m_grant          = 1'b0;
    rst_n            = 1'b0;
    data_eoc_arbiter = '0;
    TimeStamp        = '0;
    col_enable       = 1'b0;
    dout_ready       = 1'b0;
`ifdef EOC_FIFO_HWM_EN
    hwm_clr          = 1'b0;
    m_hwm            = 0;
`endif
    test_reset();
    test_single_write();
    test_fill_full();
    test_full_stream();
    test_select_only();
    test_disable_drain();
`ifdef EOC_FIFO_HWM_EN
    test_hwm();
`endif
    test_reset_mid_fill();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
